rggen_bus_arbiter: RTL and testbench

Shares one downstream `rggen_bus_if` master port between `REQUESTERS` independent upstream bus requesters, such as several external-register blocks or an external-register block and a debug port. It arbitrates round-robin and forwards exactly one transaction at a time. It captures the downstream response and returns it to the granted requester. It sits between register-block external ports and a single shared slave bus.

---
 rtl/rggen_rtl_pkg.sv | 12 +
 rtl/rggen_bus_if.sv | 27 ++
 rtl/rggen_round_robin_arbiter.sv | 42 ++++
 rtl/rggen_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register-bus blocks.
package rggen_rtl_pkg;

    // Response status returned by a register-bus slave.
    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// Register-bus interface: one request channel (valid/ready handshake)
// plus the response status and read data returned with ready.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) ();
    import rggen_rtl_pkg::*;

    logic                     valid;
    logic                     ready;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, address, write, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, address, write, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at
// i_pointer, i_pointer+1, ... (mod N). The pointer register lives in
// the parent so it only advances when a grant is actually taken.
module rggen_round_robin_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]                        i_request,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] i_pointer,
    output logic [N-1:0]                        o_grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_index
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] cand_index [N];
    logic [N-1:0]  cand_hit;

    // Candidate k is requester (pointer + k) mod N; the wrap is an explicit
    // subtract so non-power-of-2 N never selects a non-existent requester.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [PW:0] sum;
        assign sum            = {1'b0, i_pointer} + (PW+1)'(gi);
        assign cand_index[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
        assign cand_hit[gi]   = i_request[cand_index[gi]];
    end

    // First hit in pointer order wins.
    always_comb begin
        logic found;
        found   = 1'b0;
        o_index = '0;
        o_grant = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && cand_hit[k]) begin
                found   = 1'b1;
                o_index = cand_index[k];
            end
        end
        if (found) begin
            o_grant = N'(1) << o_index;
        end
    end
endmodule

// File: rtl/rggen_bus_arbiter.sv
// Shares one downstream register bus between REQUESTERS upstream
// requesters. One transaction at a time, round-robin order; the request
// is latched at grant and the response is returned with a one-cycle
// o_ready pulse to the granted requester. All outputs are registered.
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int REQUESTERS    = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [REQUESTERS-1:0]               i_valid,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [REQUESTERS-1:0]               i_write,
    input  logic [REQUESTERS*BUS_WIDTH-1:0]     i_write_data,
    input  logic [REQUESTERS*BUS_WIDTH/8-1:0]   i_strobe,
    output logic [REQUESTERS-1:0]               o_ready,
    output rggen_status                         o_status,
    output logic [BUS_WIDTH-1:0]                o_read_data,
    rggen_bus_if.master                         bus_if
);
    localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int SW = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE
    } state_t;

    state_t                   state_reg;
    logic [PW-1:0]            ptr_reg;
    logic [REQUESTERS-1:0]    grant_reg;
    logic [REQUESTERS-1:0]    ready_reg;
    rggen_status              status_reg;
    logic [BUS_WIDTH-1:0]     read_data_reg;
    logic                     valid_reg;
    logic [ADDRESS_WIDTH-1:0] address_reg;
    logic                     write_reg;
    logic [BUS_WIDTH-1:0]     write_data_reg;
    logic [SW-1:0]            strobe_reg;

    logic [REQUESTERS-1:0]    arb_grant;
    logic [PW-1:0]            arb_index;
    logic [PW-1:0]            ptr_next;

    logic [ADDRESS_WIDTH-1:0] address_slice    [REQUESTERS];
    logic [BUS_WIDTH-1:0]     write_data_slice [REQUESTERS];
    logic [SW-1:0]            strobe_slice     [REQUESTERS];

    // Split the flat request buses into per-requester slices.
    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_slice
        assign address_slice[gi]    = i_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign write_data_slice[gi] = i_write_data[gi*BUS_WIDTH +: BUS_WIDTH];
        assign strobe_slice[gi]     = i_strobe[gi*SW +: SW];
    end

    rggen_round_robin_arbiter #(
        .N (REQUESTERS)
    ) u_arbiter (
        .i_request (i_valid),
        .i_pointer (ptr_reg),
        .o_grant   (arb_grant),
        .o_index   (arb_index)
    );

    // Pointer moves just past the winner, wrapping explicitly at REQUESTERS-1.
    assign ptr_next = (arb_index == PW'(REQUESTERS - 1)) ? '0 : arb_index + PW'(1);

    // Transaction FSM: grant and latch in IDLE, hold the downstream request
    // until ready, then pulse o_ready to the winner for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            grant_reg      <= '0;
            ready_reg      <= '0;
            status_reg     <= RGGEN_OKAY;
            read_data_reg  <= '0;
            valid_reg      <= 1'b0;
            address_reg    <= '0;
            write_reg      <= 1'b0;
            write_data_reg <= '0;
            strobe_reg     <= '0;
        end else begin
            ready_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (|i_valid) begin
                        grant_reg      <= arb_grant;
                        ptr_reg        <= ptr_next;
                        address_reg    <= address_slice[arb_index];
                        write_reg      <= i_write[arb_index];
                        write_data_reg <= write_data_slice[arb_index];
                        strobe_reg     <= strobe_slice[arb_index];
                        valid_reg      <= 1'b1;
                        state_reg      <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (bus_if.ready) begin
                        status_reg    <= bus_if.status;
                        read_data_reg <= bus_if.read_data;
                        valid_reg     <= 1'b0;
                        ready_reg     <= grant_reg;
                        state_reg     <= RESPONSE;
                    end
                end
                RESPONSE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_ready           = ready_reg;
    assign o_status          = status_reg;
    assign o_read_data       = read_data_reg;
    assign bus_if.valid      = valid_reg;
    assign bus_if.address    = address_reg;
    assign bus_if.write      = write_reg;
    assign bus_if.write_data = write_data_reg;
    assign bus_if.strobe     = strobe_reg;
endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter with three requesters; the bench
// plays the downstream slave and every upstream requester.
module tb_rggen_bus_arbiter;
    import rggen_rtl_pkg::*;

    localparam int REQ = 3;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [REQ-1:0]      i_valid;
    logic [REQ*AW-1:0]   i_address;
    logic [REQ-1:0]      i_write;
    logic [REQ*DW-1:0]   i_write_data;
    logic [REQ*SW-1:0]   i_strobe;
    logic [REQ-1:0]      o_ready;
    rggen_status         o_status;
    logic [DW-1:0]       o_read_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus ();

    rggen_bus_arbiter #(
        .REQUESTERS    (REQ),
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .i_address    (i_address),
        .i_write      (i_write),
        .i_write_data (i_write_data),
        .i_strobe     (i_strobe),
        .o_ready      (o_ready),
        .o_status     (o_status),
        .o_read_data  (o_read_data),
        .bus_if       (bus)
    );

    // One line per completed transaction.
    always @(negedge clk) begin
        if (o_ready != '0)
            $display("txn done: o_ready=%b status=%0d read_data=%h", o_ready, o_status, o_read_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        i_address[r*AW +: AW]    = a;
        i_write[r]               = w;
        i_write_data[r*DW +: DW] = d;
        i_strobe[r*SW +: SW]     = s;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        i_valid      = '0;
        i_address    = '0;
        i_write      = '0;
        i_write_data = '0;
        i_strobe     = '0;
        bus.ready     = 1'b0;
        bus.status    = RGGEN_OKAY;
        bus.read_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_ready !== 3'b000) begin failures++; $display("FAIL rst_o_ready got=%b exp=000", o_ready); end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL rst_bus_valid got=%b exp=0", bus.valid); end
        checks++; if (o_status !== RGGEN_OKAY) begin failures++; $display("FAIL rst_status got=%0d exp=0", o_status); end
        checks++; if (o_read_data !== 32'h0) begin failures++; $display("FAIL rst_read_data got=%h exp=0", o_read_data); end
        checks++; if (bus.address !== 8'h00) begin failures++; $display("FAIL rst_address got=%h exp=00", bus.address); end
        checks++; if (bus.write !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", bus.write); end
        checks++; if (bus.write_data !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", bus.write_data); end
        checks++; if (bus.strobe !== 4'h0) begin failures++; $display("FAIL rst_strobe got=%h exp=0", bus.strobe); end
        checks++; if (dut.ptr_reg !== 2'd0) begin failures++; $display("FAIL rst_ptr got=%0d exp=0", dut.ptr_reg); end
        // No requests: stays idle with no downstream activity.
        tick();
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL idle_bus_valid got=%b exp=0", bus.valid); end
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(1, 8'h34, 1'b1, 32'hDEADBEEF, 4'hF);
        i_valid = 3'b010;
        tick();
        checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL wr_valid got=%b exp=1", bus.valid); end
        checks++; if (bus.address !== 8'h34) begin failures++; $display("FAIL wr_address got=%h exp=34", bus.address); end
        checks++; if (bus.write !== 1'b1) begin failures++; $display("FAIL wr_write got=%b exp=1", bus.write); end
        checks++; if (bus.write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_wdata got=%h exp=deadbeef", bus.write_data); end
        checks++; if (bus.strobe !== 4'hF) begin failures++; $display("FAIL wr_strobe got=%h exp=f", bus.strobe); end
        tick();
        tick();
        checks++; if (bus.valid !== 1'b1 || o_ready !== 3'b000) begin failures++; $display("FAIL wr_wait got valid=%b o_ready=%b exp valid=1 o_ready=000", bus.valid, o_ready); end
        bus.ready  = 1'b1;
        bus.status = RGGEN_OKAY;
        tick();
        bus.ready = 1'b0;
        i_valid   = 3'b000;
        checks++; if (o_ready !== 3'b010) begin failures++; $display("FAIL wr_o_ready got=%b exp=010", o_ready); end
        checks++; if (o_status !== RGGEN_OKAY) begin failures++; $display("FAIL wr_status got=%0d exp=0", o_status); end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL wr_valid_drop got=%b exp=0", bus.valid); end
        tick();
        checks++; if (o_ready !== 3'b000) begin failures++; $display("FAIL wr_pulse_width got=%b exp=000", o_ready); end
        tick();
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL wr_idle got=%b exp=0", bus.valid); end
    endtask

    task automatic test_read_data();
        do_reset();
        bus.ready     = 1'b1;
        bus.status    = RGGEN_SLAVE_ERROR;
        bus.read_data = 32'h12345678;
        set_req(0, 8'h10, 1'b0, 32'h0, 4'h0);
        i_valid = 3'b001;
        tick();
        checks++; if (bus.valid !== 1'b1 || bus.address !== 8'h10 || bus.write !== 1'b0) begin failures++; $display("FAIL rd_request got valid=%b addr=%h write=%b exp 1/10/0", bus.valid, bus.address, bus.write); end
        tick();
        i_valid = 3'b000;
        checks++; if (o_ready !== 3'b001) begin failures++; $display("FAIL rd_o_ready got=%b exp=001", o_ready); end
        checks++; if (o_read_data !== 32'h12345678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", o_read_data); end
        checks++; if (o_status !== RGGEN_SLAVE_ERROR) begin failures++; $display("FAIL rd_status got=%0d exp=2", o_status); end
        tick();
        checks++; if (o_ready !== 3'b000 || bus.valid !== 1'b0) begin failures++; $display("FAIL rd_end got o_ready=%b valid=%b exp 000/0", o_ready, bus.valid); end
        bus.ready  = 1'b0;
        bus.status = RGGEN_OKAY;
    endtask

    task automatic test_fairness();
        int n;
        logic [REQ-1:0] exp;
        do_reset();
        for (int r = 0; r < REQ; r++) set_req(r, 8'h40 + 8'(r), 1'b1, 32'hA000_0000 + 32'(r), 4'h1);
        i_valid   = 3'b111;
        bus.ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            tick();
            if (o_ready != '0) begin
                exp = 3'b001 << (n % 3);
                checks++; if (o_ready !== exp) begin failures++; $display("FAIL rr_order[%0d] got=%b exp=%b", n, o_ready, exp); end
                n++;
            end
        end
        checks++; if (n != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", n); end
        i_valid   = 3'b000;
        bus.ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_late_arrival();
        do_reset();
        set_req(0, 8'h20, 1'b1, 32'h0000_000A, 4'h3);
        set_req(2, 8'h22, 1'b0, 32'h0, 4'h0);
        i_valid = 3'b001;
        tick();
        // Requester 2 arrives mid-REQUEST; requester 0 also wiggles its fields.
        i_valid = 3'b101;
        set_req(0, 8'h99, 1'b0, 32'hFFFF_FFFF, 4'hC);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (bus.valid !== 1'b1 || bus.address !== 8'h20 || bus.write_data !== 32'h0000_000A || bus.strobe !== 4'h3 || o_ready !== 3'b000)
                begin failures++; $display("FAIL late_hold[%0d] got valid=%b addr=%h wdata=%h strb=%h o_ready=%b", c, bus.valid, bus.address, bus.write_data, bus.strobe, o_ready); end
        end
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        i_valid   = 3'b100;
        checks++; if (o_ready !== 3'b001) begin failures++; $display("FAIL late_r0_done got=%b exp=001", o_ready); end
        tick();
        tick();
        checks++; if (bus.valid !== 1'b1 || bus.address !== 8'h22) begin failures++; $display("FAIL late_r2_grant got valid=%b addr=%h exp 1/22", bus.valid, bus.address); end
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        i_valid   = 3'b000;
        checks++; if (o_ready !== 3'b100) begin failures++; $display("FAIL late_r2_done got=%b exp=100", o_ready); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int r = 0; r < REQ; r++) set_req(r, 8'h60 + 8'(r), 1'b0, 32'h0, 4'h0);
        i_valid = 3'b010;
        tick();
        tick();
        tick();
        // Slave finally answers in the very cycle reset hits.
        rst       = 1'b1;
        bus.ready = 1'b1;
        tick();
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.valid); end
        checks++; if (o_ready !== 3'b000) begin failures++; $display("FAIL mid_o_ready got=%b exp=000", o_ready); end
        checks++; if (dut.ptr_reg !== 2'd0) begin failures++; $display("FAIL mid_ptr got=%0d exp=0", dut.ptr_reg); end
        rst       = 1'b0;
        bus.ready = 1'b0;
        i_valid   = 3'b111;
        tick();
        checks++; if (bus.valid !== 1'b1 || bus.address !== 8'h60 || o_ready !== 3'b000) begin failures++; $display("FAIL mid_regrant got valid=%b addr=%h o_ready=%b exp 1/60/000", bus.valid, bus.address, o_ready); end
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        i_valid   = 3'b000;
        checks++; if (o_ready !== 3'b001) begin failures++; $display("FAIL mid_done got=%b exp=001", o_ready); end
        tick();
        tick();
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        set_req(0, 8'h70, 1'b0, 32'h0, 4'h0);
        set_req(2, 8'h72, 1'b0, 32'h0, 4'h0);
        bus.ready = 1'b1;
        i_valid   = 3'b100;
        tick();
        checks++; if (bus.address !== 8'h72 || dut.ptr_reg !== 2'd0) begin failures++; $display("FAIL wrap_r2 got addr=%h ptr=%0d exp 72/0", bus.address, dut.ptr_reg); end
        tick();
        i_valid = 3'b001;
        checks++; if (o_ready !== 3'b100) begin failures++; $display("FAIL wrap_r2_done got=%b exp=100", o_ready); end
        tick();
        tick();
        checks++; if (bus.valid !== 1'b1 || bus.address !== 8'h70 || dut.ptr_reg !== 2'd1) begin failures++; $display("FAIL wrap_r0 got valid=%b addr=%h ptr=%0d exp 1/70/1", bus.valid, bus.address, dut.ptr_reg); end
        tick();
        i_valid = 3'b000;
        checks++; if (o_ready !== 3'b001) begin failures++; $display("FAIL wrap_r0_done got=%b exp=001", o_ready); end
        bus.ready = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_data();
        test_fairness();
        test_late_arrival();
        test_reset_mid();
        test_pointer_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
